// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: default geometry,
// fetch FSM state type and the assembled instruction type.
package imem_fetch_ctrl_pkg;

    localparam int ADR_W_DEF    = 10;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [0:0] {
        F_HI = 1'b0,
        F_LO = 1'b1
    } fetch_state_t;

    typedef logic [31:0] inst_t;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: assembles 32-bit instructions from two 16-bit
// halfword reads of an asynchronous-read memory and hands them to decode.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADR_W    = ADR_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ADR_W-1:0] mem_adr,
    input  logic [15:0]      mem_data,
    output logic [31:0]      inst,
    output logic [ADR_W-1:0] inst_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             redirect,
    input  logic [ADR_W-1:0] redirect_pc,
    output logic [15:0]      fetch_cnt
);

    localparam logic [ADR_W-1:0] EVEN_MASK  = {{(ADR_W-1){1'b1}}, 1'b0};
    localparam logic [ADR_W-1:0] LO_BIT     = {{(ADR_W-1){1'b0}}, 1'b1};
    localparam logic [ADR_W-1:0] PC_STEP    = {{(ADR_W-2){1'b0}}, 2'b10};
    localparam logic [ADR_W-1:0] RESET_PC_A = ADR_W'(RESET_PC);
    localparam logic [ADR_W-1:0] RESET_FPC  = RESET_PC_A & EVEN_MASK;

    fetch_state_t     state_r, state_s;
    logic [ADR_W-1:0] fpc_r, fpc_s;
    logic [15:0]      hi_buf_r, hi_buf_s;
    inst_t            inst_r, inst_s;
    logic [ADR_W-1:0] inst_pc_r, inst_pc_s;
    logic             inst_valid_r, inst_valid_s;
    logic [15:0]      fetch_cnt_r, fetch_cnt_s;
    logic [ADR_W-1:0] mem_adr_s;
    logic             handshake_s;
    logic             slot_free_s;

    assign handshake_s = inst_valid_r & inst_ready;
    assign slot_free_s = ~inst_valid_r | inst_ready;

    // Next-state, halfword address and output-slot logic.
    always_comb begin
        state_s      = state_r;
        fpc_s        = fpc_r;
        hi_buf_s     = hi_buf_r;
        inst_s       = inst_r;
        inst_pc_s    = inst_pc_r;
        inst_valid_s = inst_valid_r & ~handshake_s;
        fetch_cnt_s  = fetch_cnt_r + {15'd0, handshake_s};
        mem_adr_s    = fpc_r;

        case (state_r)
            F_HI: mem_adr_s = fpc_r;
            F_LO: mem_adr_s = fpc_r | LO_BIT;
            default: mem_adr_s = fpc_r;
        endcase

        // A redirect flushes the half-assembled instruction; the handshake still counts.
        if (redirect) begin
            fpc_s        = redirect_pc & EVEN_MASK;
            state_s      = F_HI;
            inst_valid_s = 1'b0;
        end else begin
            case (state_r)
                F_HI: begin
                    hi_buf_s = mem_data;
                    state_s  = F_LO;
                end
                F_LO: begin
                    if (slot_free_s) begin
                        inst_s       = {hi_buf_r, mem_data};
                        inst_pc_s    = fpc_r;
                        inst_valid_s = 1'b1;
                        fpc_s        = fpc_r + PC_STEP;
                        state_s      = F_HI;
                    end else begin
                        state_s = F_LO;
                    end
                end
                default: begin
                    state_s = F_HI;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= F_HI;
            fpc_r        <= RESET_FPC;
            hi_buf_r     <= 16'd0;
            inst_r       <= 32'd0;
            inst_pc_r    <= '0;
            inst_valid_r <= 1'b0;
            fetch_cnt_r  <= 16'd0;
        end else begin
            state_r      <= state_s;
            fpc_r        <= fpc_s;
            hi_buf_r     <= hi_buf_s;
            inst_r       <= inst_s;
            inst_pc_r    <= inst_pc_s;
            inst_valid_r <= inst_valid_s;
            fetch_cnt_r  <= fetch_cnt_s;
        end
    end

    assign mem_adr    = mem_adr_s;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;
    assign inst_valid = inst_valid_r;
    assign fetch_cnt  = fetch_cnt_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios with literal expectations plus a
// stream-level model (word contents, pc sequence, handshake count, stall/flush rules).
module tb_imem_fetch_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect;
    logic          inst_ready;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] mem_adr;
    logic [15:0]   mem_data;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic [15:0]   fetch_cnt;

    logic [AW-1:0] mem_adr2;
    logic [15:0]   mem_data2;
    logic [31:0]   inst2;
    logic [AW-1:0] inst_pc2;
    logic          inst_valid2;
    logic [15:0]   fetch_cnt2;

    logic [15:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign mem_data  = mem[mem_adr];
    assign mem_data2 = mem[mem_adr2];

    imem_fetch_ctrl #(.ADR_W(AW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .mem_adr(mem_adr), .mem_data(mem_data),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_cnt(fetch_cnt)
    );

    imem_fetch_ctrl #(.ADR_W(AW), .RESET_PC(1020)) dut_wrap (
        .clk(clk), .rst(rst), .mem_adr(mem_adr2), .mem_data(mem_data2),
        .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2),
        .inst_ready(1'b1), .redirect(1'b0), .redirect_pc(10'd0),
        .fetch_cnt(fetch_cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return {mem[a], mem[a + 10'd1]};
    endfunction

    // Stream model: checked at every falling edge once reset has been seen.
    bit            live = 1'b0;
    logic [15:0]   m_cnt;
    logic [AW-1:0] m_exp;
    logic          p_valid, p_hs, p_ready, p_redir, p_rst;
    logic [31:0]   p_inst;
    logic [AW-1:0] p_pc;

    always @(negedge clk) begin
        if (live) begin
            chk("m_cnt", fetch_cnt, m_cnt);
            if (p_rst) begin
                chk("m_rst_inst", inst, 0);
                chk("m_rst_pc", inst_pc, 0);
                chk("m_rst_valid", inst_valid, 0);
                chk("m_rst_adr", mem_adr, 0);
            end else if (p_redir) begin
                chk("m_flush_valid", inst_valid, 0);
            end else if (p_valid && !p_ready) begin
                chk("m_stall_valid", inst_valid, 1);
                chk("m_stall_inst", inst, p_inst);
                chk("m_stall_pc", inst_pc, p_pc);
            end
            if (inst_valid === 1'b1) begin
                chk("m_word", inst, word_at(inst_pc));
                if (!p_valid || p_hs) begin
                    chk("m_seq_pc", inst_pc, m_exp);
                    m_exp = m_exp + 10'd2;
                end
            end
        end
        if (rst === 1'b1) begin
            live  = 1'b1;
            m_cnt = 16'd0;
            m_exp = 10'd0;
        end else if (live) begin
            if (inst_valid && inst_ready) m_cnt = m_cnt + 16'd1;
            if (redirect) m_exp = {redirect_pc[AW-1:1], 1'b0};
        end
        p_valid = inst_valid;
        p_hs    = inst_valid & inst_ready;
        p_ready = inst_ready;
        p_redir = redirect;
        p_rst   = rst;
        p_inst  = inst;
        p_pc    = inst_pc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 10'd0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'((i * 40503) ^ 23130);
        mem[0] = 16'hC511;
        mem[1] = 16'h1234;
        mem[2] = 16'h01F4;
        mem[3] = 16'h8002;

        // Basic fetch with ready high, plus wrap-around instance.
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("a1_adr", mem_adr, 0);
        chk("a1_valid", inst_valid, 0);
        chk("a1_cnt", fetch_cnt, 0);
        chk("w1_adr", mem_adr2, 1020);
        chk("w1_cnt", fetch_cnt2, 0);
        tick(); #1;
        chk("a2_adr", mem_adr, 1);
        chk("w2_adr", mem_adr2, 1021);
        tick(); #1;
        chk("a3_valid", inst_valid, 1);
        chk("a3_inst", inst, 32'hC5111234);
        chk("a3_pc", inst_pc, 0);
        chk("w3_pc", inst_pc2, 1020);
        chk("w3_adr", mem_adr2, 1022);
        tick(); #1;
        chk("a4_adr", mem_adr, 3);
        chk("a4_valid", inst_valid, 0);
        chk("a4_cnt", fetch_cnt, 1);
        chk("w4_adr", mem_adr2, 1023);
        tick(); #1;
        chk("a5_inst", inst, 32'h01F48002);
        chk("a5_pc", inst_pc, 2);
        chk("w5_pc", inst_pc2, 1022);
        chk("w5_adr", mem_adr2, 0);
        tick(); #1;
        chk("a6_cnt", fetch_cnt, 2);
        chk("w6_adr", mem_adr2, 1);
        tick(); #1;
        chk("w7_valid", inst_valid2, 1);
        chk("w7_pc", inst_pc2, 0);
        chk("w7_inst", inst2, 32'hC5111234);

        // Backpressure: ready low for 6 cycles with the first instruction held.
        rst = 1'b1;
        inst_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("b_valid", inst_valid, 1);
            chk("b_inst", inst, 32'hC5111234);
            chk("b_pc", inst_pc, 0);
            chk("b_cnt", fetch_cnt, 0);
            chk("b_adr", mem_adr, (i == 0) ? 2 : 3);
            tick();
        end
        inst_ready = 1'b1;
        tick(); #1;
        chk("b_next_inst", inst, 32'h01F48002);
        chk("b_next_pc", inst_pc, 2);
        chk("b_next_cnt", fetch_cnt, 1);
        chk("b_next_adr", mem_adr, 4);

        // Redirect to 9 while in F_LO at fpc=4 with the slot occupied.
        inst_ready = 1'b0;
        tick(); #1;
        chk("c_lo_adr", mem_adr, 5);
        redirect = 1'b1;
        redirect_pc = 10'd9;
        tick();
        redirect = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("c_drop_valid", inst_valid, 0);
        chk("c_adr8", mem_adr, 8);
        chk("c_cnt", fetch_cnt, 1);
        tick(); #1;
        chk("c_adr9", mem_adr, 9);
        tick(); #1;
        chk("c_pc8", inst_pc, 8);
        chk("c_word8", inst, word_at(10'd8));

        // Redirect coincident with an accepted handshake.
        redirect = 1'b1;
        redirect_pc = 10'd20;
        tick();
        redirect = 1'b0;
        #1;
        chk("d_cnt", fetch_cnt, 2);
        chk("d_valid", inst_valid, 0);
        chk("d_adr", mem_adr, 20);
        tick(); tick(); #1;
        chk("d_pc20", inst_pc, 20);

        // Reset in F_LO at fpc=6, with a simultaneous redirect that must lose.
        redirect = 1'b1;
        redirect_pc = 10'd6;
        tick();
        redirect = 1'b0;
        #1;
        chk("e_adr6", mem_adr, 6);
        chk("e_cnt", fetch_cnt, 3);
        tick(); #1;
        chk("e_adr7", mem_adr, 7);
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 10'd40;
        tick();
        rst = 1'b0;
        redirect = 1'b0;
        #1;
        chk("e_inst0", inst, 0);
        chk("e_pc0", inst_pc, 0);
        chk("e_valid0", inst_valid, 0);
        chk("e_cnt0", fetch_cnt, 0);
        chk("e_adr0", mem_adr, 0);
        tick(); #1;
        chk("e_adr1", mem_adr, 1);
        tick(); #1;
        chk("e_inst", inst, 32'hC5111234);
        chk("e_pc", inst_pc, 0);
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
